// File: rtl/generator_ferestre.sv
// 2x2 window generator: slices a raster-order pixel stream into
// non-overlapping 2x2 windows. Even rows are parked in a line buffer of
// column pairs; odd rows pair with them to form complete windows.
module generator_ferestre #(
  parameter int LATIME_IMG   = 28,
  parameter int INALTIME_IMG = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       sincron,
  output logic [7:0] intrare1,
  output logic [7:0] intrare2,
  output logic [7:0] intrare3,
  output logic [7:0] intrare4,
  output logic       activare_tragere,
  output logic       cadru_gata
);

  localparam int CW    = (LATIME_IMG > 1) ? $clog2(LATIME_IMG) : 1;
  localparam int RW    = (INALTIME_IMG > 1) ? $clog2(INALTIME_IMG) : 1;
  localparam int PAIRS = LATIME_IMG / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic {
    RAND_PAR   = 1'b0,
    RAND_IMPAR = 1'b1
  } stare_t;

  stare_t          state_reg;
  stare_t          cur_state;
  logic [CW-1:0]   col_reg;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   row_reg;
  logic [RW-1:0]   cur_row;
  logic            col_last;
  logic            row_last;
  logic            wr_en;
  logic            rd_en;
  logic [PW-1:0]   pair_idx;

  // Line buffer holds one even row as column pairs {odd, even}, so a
  // single registered read fetches both top pixels of a window.
  logic [15:0]     line_buf [0:PAIRS-1];
  logic [7:0]      even_hold;
  logic [15:0]     top_pair;
  logic [7:0]      bottom_left;

  // Effective position for this edge: sincron restarts the frame so the
  // pixel accepted alongside it lands at row 0, column 0.
  always_comb begin
    cur_state = state_reg;
    cur_col   = col_reg;
    cur_row   = row_reg;
    if (sincron) begin
      cur_state = RAND_PAR;
      cur_col   = '0;
      cur_row   = '0;
    end
    col_last = (cur_col == CW'(LATIME_IMG - 1));
    row_last = (cur_row == RW'(INALTIME_IMG - 1));
    pair_idx = PW'(cur_col >> 1);
    wr_en    = pixel_valid && (cur_state == RAND_PAR) && cur_col[0];
    rd_en    = pixel_valid && (cur_state == RAND_IMPAR) && !cur_col[0];
  end

  // Line buffer storage: write the completed pair on odd columns of even
  // rows, prefetch the pair on even columns of odd rows. Each location is
  // read during the odd row long before the next even row rewrites it.
  always_ff @(posedge clk) begin
    if (pixel_valid && (cur_state == RAND_PAR) && !cur_col[0])
      even_hold <= pixel_in;
    if (wr_en)
      line_buf[pair_idx] <= {pixel_in, even_hold};
    if (rd_en)
      top_pair <= line_buf[pair_idx];
  end

  // Position counters, row-parity FSM and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RAND_PAR;
      col_reg          <= '0;
      row_reg          <= '0;
      bottom_left      <= '0;
      intrare1         <= '0;
      intrare2         <= '0;
      intrare3         <= '0;
      intrare4         <= '0;
      activare_tragere <= 1'b0;
      cadru_gata       <= 1'b0;
    end else begin
      activare_tragere <= 1'b0;
      cadru_gata       <= 1'b0;
      if (pixel_valid) begin
        if (col_last) begin
          col_reg   <= '0;
          row_reg   <= row_last ? '0 : cur_row + 1'b1;
          state_reg <= (cur_state == RAND_PAR) ? RAND_IMPAR : RAND_PAR;
        end else begin
          col_reg   <= cur_col + 1'b1;
          row_reg   <= cur_row;
          state_reg <= cur_state;
        end
        if (cur_state == RAND_IMPAR) begin
          if (!cur_col[0]) begin
            bottom_left <= pixel_in;
          end else begin
            intrare1         <= top_pair[7:0];
            intrare2         <= top_pair[15:8];
            intrare3         <= bottom_left;
            intrare4         <= pixel_in;
            activare_tragere <= 1'b1;
            cadru_gata       <= col_last && row_last;
          end
        end
      end else begin
        col_reg   <= cur_col;
        row_reg   <= cur_row;
        state_reg <= cur_state;
      end
    end
  end

endmodule

// File: tb/tb_generator_ferestre.sv
// Bench for the 2x2 window generator on a 4x4 frame: a frame-image model
// predicts every cycle's outputs, literal window lists pin the model.
module tb_generator_ferestre;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       pixel_valid = 1'b0;
  logic       sincron = 1'b0;
  logic [7:0] intrare1, intrare2, intrare3, intrare4;
  logic       activare_tragere, cadru_gata;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          pos = 0;
  logic [7:0]  img [0:H-1][0:W-1];
  logic [31:0] exp_win = '0;
  logic        exp_pulse = 1'b0;
  logic        exp_cg = 1'b0;

  // windows and frame-done pulses seen on the DUT
  logic [31:0] win_q[$];
  int          cg_cnt = 0;
  int          cg_at[$];

  generator_ferestre #(.LATIME_IMG(W), .INALTIME_IMG(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .sincron(sincron), .intrare1(intrare1), .intrare2(intrare2),
    .intrare3(intrare3), .intrare4(intrare4),
    .activare_tragere(activare_tragere), .cadru_gata(cadru_gata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w4(input int a, input int b, input int c, input int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input logic [7:0] p, input logic v, input logic s);
    int r, c;
    logic [31:0] got;
    pixel_in = p; pixel_valid = v; sincron = s;
    @(posedge clk);
    exp_pulse = 1'b0;
    exp_cg    = 1'b0;
    if (!rst_n) begin
      pos     = 0;
      exp_win = '0;
    end else begin
      if (s) pos = 0;
      if (v) begin
        r = pos / W;
        c = pos % W;
        img[r][c] = p;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_win   = {img[r-1][c-1], img[r-1][c], img[r][c-1], p};
          exp_pulse = 1'b1;
          exp_cg    = (pos == W*H - 1);
        end
        pos = (pos + 1) % (W*H);
      end
    end
    #1;
    got = {intrare1, intrare2, intrare3, intrare4};
    chk("activare_tragere", {31'b0, activare_tragere}, {31'b0, exp_pulse});
    chk("cadru_gata", {31'b0, cadru_gata}, {31'b0, exp_cg});
    chk("window", got, exp_win);
    if (activare_tragere) win_q.push_back(got);
    if (cadru_gata) begin
      cg_cnt++;
      cg_at.push_back(win_q.size());
    end
    $display("t=%0t pix=%0d v=%b s=%b rst_n=%b -> pulse=%b cg=%b win=%h",
             $time, p, v, s, rst_n, activare_tragere, cadru_gata, got);
  endtask

  task automatic clear_log();
    win_q.delete();
    cg_at.delete();
    cg_cnt = 0;
  endtask

  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) step(8'(first + i), 1'b1, 1'b0);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(8'hAA, 1'b1, 1'b0);
    rst_n = 1'b1;

    // continuous frame 0..15
    clear_log();
    stream(0, 16);
    chk("s1 count", 32'(win_q.size()), 32'd4);
    if (win_q.size() == 4) begin
      chk("s1 w0", win_q[0], w4(0, 1, 4, 5));
      chk("s1 w1", win_q[1], w4(2, 3, 6, 7));
      chk("s1 w2", win_q[2], w4(8, 9, 12, 13));
      chk("s1 w3", win_q[3], w4(10, 11, 14, 15));
    end
    chk("s1 cg count", 32'(cg_cnt), 32'd1);
    if (cg_at.size() == 1) chk("s1 cg on 4th", 32'(cg_at[0]), 32'd4);

    // valid toggling, with one long gap
    clear_log();
    for (int i = 0; i < 16; i++) begin
      step(8'(i), 1'b1, 1'b0);
      step(8'hEE, 1'b0, 1'b0);
      if (i == 9) for (int k = 0; k < 5; k++) step(8'h77, 1'b0, 1'b0);
    end
    chk("s2 count", 32'(win_q.size()), 32'd4);
    if (win_q.size() == 4) begin
      chk("s2 w1", win_q[1], w4(2, 3, 6, 7));
      chk("s2 w3", win_q[3], w4(10, 11, 14, 15));
    end

    // back-to-back frames
    clear_log();
    stream(0, 16);
    stream(100, 16);
    chk("s3 count", 32'(win_q.size()), 32'd8);
    if (win_q.size() == 8) chk("s3 w4", win_q[4], w4(100, 101, 104, 105));
    chk("s3 cg count", 32'(cg_cnt), 32'd2);
    if (cg_at.size() == 2) begin
      chk("s3 cg on 4th", 32'(cg_at[0]), 32'd4);
      chk("s3 cg on 8th", 32'(cg_at[1]), 32'd8);
    end

    // reset mid-frame after pixel 9
    stream(0, 10);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(8'h33, 1'b1, 1'b0);
    rst_n = 1'b1;
    clear_log();
    stream(20, 16);
    chk("s4 count", 32'(win_q.size()), 32'd4);
    if (win_q.size() > 0) chk("s4 w0", win_q[0], w4(20, 21, 24, 25));

    // sincron with pixel 50 after pixel 6
    stream(0, 7);
    clear_log();
    step(8'd50, 1'b1, 1'b1);
    stream(51, 15);
    chk("s5 count", 32'(win_q.size()), 32'd4);
    if (win_q.size() > 0) chk("s5 w0", win_q[0], w4(50, 51, 54, 55));

    // sincron alone, then all-255 frame
    step(8'h00, 1'b0, 1'b1);
    clear_log();
    for (int i = 0; i < 16; i++) step(8'hFF, 1'b1, 1'b0);
    chk("s6 count", 32'(win_q.size()), 32'd4);
    foreach (win_q[i]) chk("s6 w255", win_q[i], 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
